// File: rtl/cpu_types_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types: machine word, ALU opcodes, ALU
//               flag bundle and the captured ALU result record.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int ALUOP_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // Bit order is {overflow, negative, zero} when viewed as a 3-bit vector.
  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

  typedef struct packed {
    word_t      out;
    alu_flags_t flags;
  } alu_res_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_if
// Description : Connection bundle between a command driver and the
//               combinational ALU. The tb modport drives operands and samples
//               the result; the alu modport is the ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t op;
  word_t  a;
  word_t  b;
  word_t  out;
  logic   zero_flag;
  logic   negative_flag;
  logic   overflow_flag;

  modport alu (
    input  op, a, b,
    output out, zero_flag, negative_flag, overflow_flag
  );

  modport tb (
    output op, a, b,
    input  out, zero_flag, negative_flag, overflow_flag
  );

endinterface : alu_if
`default_nettype wire

// File: rtl/res_buf2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : res_buf2
// Description : Two-entry shift buffer with an EMPTY/ONE/FULL occupancy FSM.
//               Entry 0 is always the head; a pop from FULL shifts entry 1
//               down. full/empty are registered so consumers of them see no
//               combinational path from push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module res_buf2
  import cpu_types_pkg::*;
#(
  parameter type T = alu_res_t
) (
  input  logic CLK,
  input  logic nRST,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head_data,
  output logic full,
  output logic empty
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  occ_t state_q;
  T     ent0_q;
  T     ent1_q;
  logic full_q;
  logic empty_q;

  // Occupancy FSM with storage and registered status flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            ent0_q  <= push_data;
            state_q <= ST_ONE;
            empty_q <= 1'b0;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            // Head leaves and the new entry takes its place.
            ent0_q <= push_data;
          end else if (push) begin
            ent1_q  <= push_data;
            state_q <= ST_FULL;
            full_q  <= 1'b1;
          end else if (pop) begin
            // Head word is kept so the output holds its last value.
            state_q <= ST_EMPTY;
            empty_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (pop) begin
            ent0_q  <= ent1_q;
            state_q <= ST_ONE;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          full_q  <= 1'b0;
          empty_q <= 1'b1;
        end
      endcase
    end
  end

  assign head_data = ent0_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule : res_buf2
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_cmd_seq
// Description : Command-side ALU sequencer. Drives op/a/b into a
//               combinational ALU from a valid/ready command port, captures
//               the result and flags into a 2-entry buffer, and keeps an
//               accumulator, a sticky overflow bit and an issued-op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_seq
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  alu_if.tb                aluif,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  aluop_t           cmd_op,
  input  word_t            cmd_a,
  input  word_t            cmd_b,
  input  logic             cmd_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output word_t            res_out,
  output logic [2:0]       res_flags,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  word_t            acc_q;
  word_t            acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             accept;
  logic             pop;
  logic             buf_full;
  logic             buf_empty;
  alu_res_t         push_res;
  alu_res_t         head_res;

  // ALU operands follow the command port; idle bus is all zeros.
  always_comb begin
    aluif.op = aluop_t'(4'd0);
    aluif.a  = '0;
    aluif.b  = '0;
    if (cmd_valid) begin
      aluif.op = cmd_op;
      aluif.a  = cmd_acc ? acc_q : cmd_a;
      aluif.b  = cmd_b;
    end
  end

  // Handshakes and the result record captured on accept.
  always_comb begin
    accept                  = cmd_valid && !buf_full;
    pop                     = !buf_empty && res_ready;
    push_res.out            = aluif.out;
    push_res.flags.overflow = aluif.overflow_flag;
    push_res.flags.negative = aluif.negative_flag;
    push_res.flags.zero     = aluif.zero_flag;
  end

  // Next state for accumulator, counter and sticky overflow; set beats clear.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      acc_d = aluif.out;
      cnt_d = cnt_q + CNT_ONE;
    end
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (accept && aluif.overflow_flag) begin
      ovf_d = 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  res_buf2 #(
    .T (alu_res_t)
  ) u_res_buf2 (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (accept),
    .push_data (push_res),
    .pop       (pop),
    .head_data (head_res),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign cmd_ready  = !buf_full;
  assign res_valid  = !buf_empty;
  assign res_out    = head_res.out;
  assign res_flags  = head_res.flags;
  assign ovf_sticky = ovf_q;
  assign op_count   = cnt_q;

endmodule : alu_cmd_seq
`default_nettype wire
